keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives one active-low column at a time on a 4x4 keypad,
// samples the synchronized rows and publishes a debounced key with press/release pulses.
module keypad_scanner #(
  parameter int SCAN_TICKS      = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release,
  output logic       multi_key
);

  localparam int                TICK_W     = $clog2(SCAN_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_TICKS - 1);
  localparam logic [3:0]        STABLE_MAX = 4'(DEBOUNCE_FRAMES);

  // The candidate kinds reuse the committed-state encoding: IDLE doubles as NONE.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_MULTI = 2'd2} state_e;

  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  logic [3:0]        rows_meta_q, rows_meta_d, rows_sync_q, rows_sync_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        cols_q, cols_d;
  logic [15:0]       frame_q, frame_d;
  logic [3:0]        stable_q, stable_d;
  state_e            prev_kind_q, prev_kind_d, state_q, state_d;
  logic [3:0]        prev_code_q, prev_code_d, key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d, multi_key_q, multi_key_d;
  logic              key_press_q, key_press_d, key_release_q, key_release_d;

  logic              sample_now, frame_end, cand_match, cand_new;
  logic [4:0]        cand_ones;
  logic [3:0]        cand_code;
  state_e            cand_kind;

  // Scan timing, frame capture, debounce and commit decision.
  always_comb begin
    rows_meta_d   = rows;
    rows_sync_d   = rows_meta_q;
    tick_d        = tick_q;
    col_idx_d     = col_idx_q;
    frame_d       = frame_q;
    stable_d      = stable_q;
    prev_kind_d   = prev_kind_q;
    prev_code_d   = prev_code_q;
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    cand_ones     = 5'd0;
    cand_kind     = S_IDLE;
    cand_code     = 4'd0;
    cand_match    = 1'b0;
    cand_new      = 1'b0;
    sample_now    = (tick_q == TICK_LAST);
    frame_end     = sample_now && (col_idx_q == 2'd3);

    if (sample_now) begin
      tick_d    = {TICK_W{1'b0}};
      col_idx_d = col_idx_q + 2'd1;
      for (int r = 0; r < 4; r++) frame_d[{r[1:0], col_idx_q}] = ~rows_sync_q[r[1:0]];
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end

    if (frame_end) begin
      cand_ones = count_ones(frame_d);
      cand_code = lowest_set(frame_d);
      if (cand_ones == 5'd0)      cand_kind = S_IDLE;
      else if (cand_ones == 5'd1) cand_kind = S_HELD;
      else                        cand_kind = S_MULTI;

      cand_match = (cand_kind == prev_kind_q) &&
                   ((cand_kind != S_HELD) || (cand_code == prev_code_q));
      if (cand_match) stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 4'd1;
      else            stable_d = 4'd1;
      prev_kind_d = cand_kind;
      prev_code_d = cand_code;

      // key_code_q is the committed code whenever the state is HELD.
      cand_new = (cand_kind != state_q) ||
                 ((cand_kind == S_HELD) && (cand_code != key_code_q));
      if ((stable_d == STABLE_MAX) && cand_new) begin
        state_d       = cand_kind;
        key_press_d   = (cand_kind == S_HELD);
        key_release_d = (state_q == S_HELD);
        if (cand_kind == S_HELD) key_code_d = cand_code;
        else                     key_code_d = key_code_q;
      end else begin
        state_d = state_q;
      end
    end else begin
      stable_d = stable_q;
    end

    cols_d      = ~(4'b0001 << col_idx_d);
    key_valid_d = (state_d == S_HELD);
    multi_key_d = (state_d == S_MULTI);
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rows_meta_q   <= 4'hF;
      rows_sync_q   <= 4'hF;
      tick_q        <= {TICK_W{1'b0}};
      col_idx_q     <= 2'd0;
      cols_q        <= 4'b1110;
      frame_q       <= 16'd0;
      stable_q      <= 4'd0;
      prev_kind_q   <= S_IDLE;
      prev_code_q   <= 4'd0;
      state_q       <= S_IDLE;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      multi_key_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      rows_meta_q   <= rows_meta_d;
      rows_sync_q   <= rows_sync_d;
      tick_q        <= tick_d;
      col_idx_q     <= col_idx_d;
      cols_q        <= cols_d;
      frame_q       <= frame_d;
      stable_q      <= stable_d;
      prev_kind_q   <= prev_kind_d;
      prev_code_q   <= prev_code_d;
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      multi_key_q   <= multi_key_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign cols        = cols_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign multi_key   = multi_key_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving rows from cols, a frame-level reference
// model that queues expected output events, and a monitor comparing them.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DF = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] pressed = 16'd0;
  logic [3:0]  rows, cols, key_code;
  logic        key_valid, key_press, key_release, multi_key;

  always #5 CLK = ~CLK;

  // A pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
  end

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_FRAMES(DF)) dut (
    .CLK(CLK), .RST(RST), .rows(rows), .cols(cols), .key_code(key_code),
    .key_valid(key_valid), .key_press(key_press), .key_release(key_release),
    .multi_key(multi_key)
  );

  typedef struct {
    int         cyc;
    bit         press;
    bit         rel;
    bit         valid;
    bit         multi;
    logic [3:0] code;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;

  // Reference model state: cycles since reset, committed candidate (-1 none, 0..15 key, 16 multi).
  int          k = 0;
  int          m_comm = -1;
  logic [3:0]  m_code = 4'd0;
  logic [15:0] m_frame = 16'd0;
  logic [15:0] ph0 = 16'd0, ph1 = 16'd0, ph2 = 16'd0;
  int          cand_hist[$];

  task automatic model_step();
    int  c, n, cand;
    bit  run_ok;
    ev_t e;
    cyc++;
    ph2 = ph1; ph1 = ph0; ph0 = pressed;
    if (RST) begin
      if (m_comm != -1 || m_code != 4'd0) begin
        e.cyc = cyc; e.press = 1'b0; e.rel = 1'b0; e.valid = 1'b0; e.multi = 1'b0; e.code = 4'd0;
        exp_q.push_back(e);
      end
      k = 0; m_comm = -1; m_code = 4'd0; m_frame = 16'd0;
      cand_hist.delete();
    end else begin
      k++;
      if ((k - 1) % ST == ST - 1) begin
        c = ((k - 1) / ST) % 4;
        // The row value seen by the sample was on the pins two edges earlier.
        for (int r = 0; r < 4; r++) m_frame[r*4 + c] = ph2[r*4 + c];
        if (c == 3) begin
          n = $countones(m_frame);
          cand = 16;
          if (n == 0) cand = -1;
          else if (n == 1) for (int i = 15; i >= 0; i--) if (m_frame[i]) cand = i;
          cand_hist.push_back(cand);
          if (cand_hist.size() > DF) cand_hist.delete(0);
          run_ok = (cand_hist.size() == DF);
          foreach (cand_hist[i]) if (cand_hist[i] != cand) run_ok = 1'b0;
          if (run_ok && cand != m_comm) begin
            e.cyc   = cyc;
            e.press = (cand >= 0 && cand < 16);
            e.rel   = (m_comm >= 0 && m_comm < 16);
            e.valid = e.press;
            e.multi = (cand == 16);
            if (e.press) m_code = cand[3:0];
            e.code  = m_code;
            m_comm  = cand;
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  bit         mon_en = 1'b0;
  logic       pv = 1'b0, pm = 1'b0;
  logic [3:0] pc = 4'd0;
  int         press_count = 0, rel_count = 0, both_seen = 0, last_press_cyc = -1;
  ev_t        mon_e;

  // Monitor: any pulse or level change on the key outputs is an event to match.
  initial forever begin
    @(negedge CLK);
    if (mon_en) begin
      if (key_press) begin press_count++; last_press_cyc = cyc; end
      if (key_release) rel_count++;
      if (key_press && key_release) both_seen++;
      if (key_press || key_release || key_valid !== pv || multi_key !== pm || key_code !== pc) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d got p=%0b r=%0b v=%0b m=%0b code=%h, expected no event",
                   cyc, key_press, key_release, key_valid, multi_key, key_code);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.press !== key_press || mon_e.rel !== key_release ||
              mon_e.valid !== key_valid || mon_e.multi !== multi_key || mon_e.code !== key_code) begin
            fails++;
            $display("FAIL event got cyc=%0d p=%0b r=%0b v=%0b m=%0b code=%h, expected cyc=%0d p=%0b r=%0b v=%0b m=%0b code=%h",
                     cyc, key_press, key_release, key_valid, multi_key, key_code,
                     mon_e.cyc, mon_e.press, mon_e.rel, mon_e.valid, mon_e.multi, mon_e.code);
          end
        end
      end
      pv = key_valid; pm = multi_key; pc = key_code;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [3:0] exp_cols;
  int         press_cyc, lat, pc0, rc0;

  initial begin
    RST = 1'b1;
    pressed = 16'd0;
    hold(3);
    RST = 1'b0;
    mon_en = 1'b1;

    // Idle: column walk from the bench's own cycle count.
    repeat (200) begin
      @(negedge CLK);
      exp_cols = ~(4'b0001 << ((k / ST) % 4));
      check("idle_cols", cols, exp_cols);
    end
    check("idle_valid", key_valid, 1'b0);
    check("idle_multi", multi_key, 1'b0);

    // Clean press of (2,1) with latency window, then release.
    last_press_cyc = -1;
    press_cyc = cyc;
    pressed = 16'h0200;
    hold(100);
    lat = last_press_cyc - press_cyc;
    checks++;
    if (last_press_cyc < 0 || lat < 32 || lat > 67) begin
      fails++;
      $display("FAIL press_latency got=%0d expected 32..67", lat);
    end
    check("held_valid", key_valid, 1'b1);
    check("held_code", key_code, 4'b1001);
    pressed = 16'd0;
    hold(100);
    check("rel_valid", key_valid, 1'b0);
    check("rel_code_kept", key_code, 4'b1001);

    // One-frame bounce on (0,3) must never commit.
    pc0 = press_count; rc0 = rel_count;
    repeat (5) begin
      pressed = 16'h0008; hold(16);
      pressed = 16'd0;    hold(16);
    end
    check("bounce_press", press_count, pc0);
    check("bounce_release", rel_count, rc0);
    pressed = 16'h0008;
    hold(100);
    check("bounce_then_hold_press", press_count, pc0 + 1);
    check("bounce_then_hold_code", key_code, 4'b0011);
    pressed = 16'd0;
    hold(100);

    // Multi-key entry and exit.
    pressed = 16'h0010; hold(100);
    check("single_code", key_code, 4'b0100);
    pressed = 16'h4010; hold(100);
    check("multi_on", multi_key, 1'b1);
    check("multi_valid", key_valid, 1'b0);
    pressed = 16'h4000; hold(100);
    check("multi_exit_code", key_code, 4'b1110);
    check("multi_exit_multi", multi_key, 1'b0);
    check("multi_exit_valid", key_valid, 1'b1);
    pressed = 16'd0; hold(100);

    // Direct key-to-key switch.
    pressed = 16'h0200; hold(100);
    both_seen = 0;
    pressed = 16'h0001; hold(100);
    check("switch_both_pulses", both_seen, 1);
    check("switch_code", key_code, 4'b0000);

    // Reset while held.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_valid", key_valid, 1'b0);
    check("rst_press", key_press, 1'b0);
    check("rst_release", key_release, 1'b0);
    check("rst_multi", multi_key, 1'b0);
    check("rst_code", key_code, 4'b0000);
    check("rst_cols", cols, 4'b1110);
    pc0 = press_count;
    hold(100);
    check("rst_fresh_press", press_count, pc0 + 1);
    check("rst_fresh_valid", key_valid, 1'b1);
    pressed = 16'd0; hold(100);

    // Random segments of none/single/double presses with occasional resets.
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 2))
        0:       pressed = 16'd0;
        1:       pressed = 16'h0001 << $urandom_range(0, 15);
        default: pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
      hold($urandom_range(4, 70));
    end
    pressed = 16'd0;
    hold(100);
    check("drain_expected_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
